mult_div_unit: RTL and testbench

- Iterative signed multiply/divide unit for the multicycle MIPS core.
- Takes the A/B register values for MULT/DIV and produces the HI/LO values read by MFHI/MFLO.
- The control FSM issues a one-cycle start, then waits on busy/done before the next HI/LO access.
- One clock; reset is synchronous and active-high.

---
 rtl/mult_div_unit.sv | 127 ++++++++++++
 tb/tb_mult_div_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit producing HI/LO for MULT/DIV.
// Works on operand magnitudes for WIDTH cycles, then applies signs in FIX.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    op,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic                    busy,
    output logic                    done,
    output logic                    div_zero,
    output logic        [WIDTH-1:0] hi,
    output logic        [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MULT, DIV, FIX} state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     opnd;
    logic                 sign_a;
    logic                 sign_b;
    logic                 is_div;

    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_tmp;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   div_next;

    // The most negative value keeps its bit pattern and is read as unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] x);
        return x[WIDTH-1] ? $unsigned(-x) : $unsigned(x);
    endfunction

    function automatic logic [WIDTH-1:0] sign_w(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] sign_2w(input logic [2*WIDTH-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

    // acc holds {partial product, multiplier} for MULT and {remainder, dividend/quotient} for DIV.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        div_tmp  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff = div_tmp - {1'b0, opnd};
        div_next = div_diff[WIDTH] ? {div_tmp[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                   : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            is_div   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_a <= a[WIDTH-1];
                        sign_b <= b[WIDTH-1];
                        is_div <= op;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        opnd   <= op ? mag(b) : mag(a);
                        acc    <= {{WIDTH{1'b0}}, (op ? mag(a) : mag(b))};
                        state  <= op ? DIV : MULT;
                    end
                end
                MULT: begin
                    acc <= {mul_sum, acc[WIDTH-1:1]};
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST)
                        state <= FIX;
                end
                DIV: begin
                    if (opnd == '0) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        div_zero <= 1'b1;
                    end else begin
                        acc <= div_next;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST)
                            state <= FIX;
                    end
                end
                FIX: begin
                    if (is_div) begin
                        lo <= sign_w(acc[WIDTH-1:0], sign_a ^ sign_b);
                        hi <= sign_w(acc[2*WIDTH-1:WIDTH], sign_a);
                    end else begin
                        {hi, lo} <= sign_2w(acc, sign_a ^ sign_b);
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit with a scoreboard of expected HI/LO results.
module tb_mult_div_unit;

    localparam int W = 32;

    logic                clock = 1'b0;
    logic                reset;
    logic                start;
    logic                op;
    logic signed [W-1:0] a;
    logic signed [W-1:0] b;
    logic                busy;
    logic                done;
    logic                div_zero;
    logic [W-1:0]        hi;
    logic [W-1:0]        lo;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           at;
        string        tag;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    int           tests = 0;
    int           fails = 0;
    int           cyc = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model: 64-bit signed arithmetic, truncated to HI/LO.
    task automatic launch(input string tag, input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t   e;
        longint la, lb, p, q, r;
        la = longint'($signed(x));
        lb = longint'($signed(y));
        e.dz = 1'b0;
        e.at = cyc + 34;
        if (o && y == '0) begin
            e.hi = m_hi;
            e.lo = m_lo;
            e.dz = 1'b1;
            e.at = cyc + 2;
        end else if (!o) begin
            p = la * lb;
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else begin
            q = la / lb;
            r = la % lb;
            e.hi = r[31:0];
            e.lo = q[31:0];
        end
        e.tag = tag;
        m_hi = e.hi;
        m_lo = e.lo;
        sb.push_back(e);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clock);
        start = 1'b0;
        op    = ~o;
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 80 && sb.size() != 0; i++)
            @(negedge clock);
        @(negedge clock);
        check({tag, "_drain"}, 64'(sb.size()), 64'd0);
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    always @(negedge clock) begin
        if (reset === 1'b0 && done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(done), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.tag, "_hi"}, 64'(hi), 64'(mon_e.hi));
                check({mon_e.tag, "_lo"}, 64'(lo), 64'(mon_e.lo));
                check({mon_e.tag, "_dz"}, 64'(div_zero), 64'(mon_e.dz));
                check({mon_e.tag, "_cycle"}, 64'(cyc), 64'(mon_e.at));
            end
        end
        if (div_zero === 1'b1 && done !== 1'b1)
            check("dz_without_done", 64'(done), 64'd1);
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int bad;
        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clock);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dz", 64'(div_zero), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        // MULT 7 * -3 with busy window
        launch("mul_7_m3", 1'b0, 32'd7, 32'hFFFF_FFFD);
        bad = 0;
        for (int i = 0; i < 33; i++) begin
            if (busy !== 1'b1) bad++;
            if (done !== 1'b0) bad++;
            @(negedge clock);
        end
        check("t1_busy_window", 64'(bad), 64'd0);
        check("t1_done_busy", 64'(busy), 64'd0);
        check("t1_done", 64'(done), 64'd1);
        check("t1_hi", 64'(hi), 64'hFFFF_FFFF);
        check("t1_lo", 64'(lo), 64'hFFFF_FFEB);
        wait_idle("t1");

        // Signed divides
        launch("div_100_7", 1'b1, 32'd100, 32'd7);
        wait_idle("t2a");
        check("t2a_lo", 64'(lo), 64'd14);
        check("t2a_hi", 64'(hi), 64'd2);
        launch("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_idle("t2b");
        check("t2b_lo", 64'(lo), 64'hFFFF_FFFD);
        check("t2b_hi", 64'(hi), 64'hFFFF_FFFF);
        launch("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
        wait_idle("t2c");
        check("t2c_lo", 64'(lo), 64'hFFFF_FFFD);
        check("t2c_hi", 64'(hi), 64'd1);

        // Divide by zero keeps HI/LO
        launch("div_pre", 1'b1, 32'd100, 32'd7);
        wait_idle("t3pre");
        launch("div_by0", 1'b1, 32'd5, 32'd0);
        check("t3_busy_e0", 64'(busy), 64'd1);
        check("t3_done_e0", 64'(done), 64'd0);
        @(negedge clock);
        check("t3_busy_e1", 64'(busy), 64'd0);
        check("t3_done_e1", 64'(done), 64'd1);
        check("t3_dz_e1", 64'(div_zero), 64'd1);
        check("t3_hi", 64'(hi), 64'd2);
        check("t3_lo", 64'(lo), 64'd14);
        @(negedge clock);
        check("t3_done_clr", 64'(done), 64'd0);
        check("t3_dz_clr", 64'(div_zero), 64'd0);
        wait_idle("t3");

        // Most negative operand
        launch("mul_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000);
        wait_idle("t4a");
        check("t4a_hi", 64'(hi), 64'h4000_0000);
        check("t4a_lo", 64'(lo), 64'd0);
        launch("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle("t4b");
        check("t4b_lo", 64'(lo), 64'h8000_0000);
        check("t4b_hi", 64'(hi), 64'd0);

        // Start while busy is ignored
        launch("mul_ignore", 1'b0, 32'h0001_2345, 32'hFFFF_F889);
        repeat (4) @(negedge clock);
        start = 1'b1;
        op    = 1'b1;
        a     = 32'd9;
        b     = 32'd3;
        @(negedge clock);
        start = 1'b0;
        wait_idle("t5a");

        // Reset in the middle of a DIV
        start = 1'b1;
        op    = 1'b1;
        a     = 32'd1000;
        b     = 32'd3;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("t5_rst_hi", 64'(hi), 64'd0);
        check("t5_rst_lo", 64'(lo), 64'd0);
        check("t5_rst_busy", 64'(busy), 64'd0);
        check("t5_rst_done", 64'(done), 64'd0);
        reset = 1'b0;
        m_hi  = '0;
        m_lo  = '0;
        repeat (40) @(negedge clock);
        check("t5_abort_hi", 64'(hi), 64'd0);
        check("t5_abort_busy", 64'(busy), 64'd0);
        launch("mul_3_4", 1'b0, 32'd3, 32'd4);
        wait_idle("t5b");
        check("t5b_lo", 64'(lo), 64'd12);
        check("t5b_hi", 64'(hi), 64'd0);

        // Back-to-back: DIV started in the MULT done cycle
        launch("b2b_mul", 1'b0, 32'hFFFF_FFFB, 32'd6);
        for (int i = 0; i < 40 && done !== 1'b1; i++)
            @(negedge clock);
        check("t6_mul_done_seen", 64'(done), 64'd1);
        launch("b2b_div", 1'b1, 32'hFFFF_FC18, 32'd7);
        wait_idle("t6");
        check("t6_lo", 64'(lo), 64'hFFFF_FF72);
        check("t6_hi", 64'(hi), 64'hFFFF_FFFA);

        // A few random operations against the model
        for (int k = 0; k < 6; k++) begin
            logic [W-1:0] x, y;
            x = $urandom;
            y = $urandom;
            if (y == '0) y = 32'd1;
            launch("rand", 1'(k % 2), x, y);
            wait_idle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
